// File: rtl/dag_circ_top.sv
// Data address generator: NREG channels of I/M/L/B registers with pre/post-modify,
// circular wrap, bit-reversed addressing and a bus-connect register port.
module dag_circ_top #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int IDX_W = $clog2(NREG),
  localparam int RA_W  = IDX_W + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps_dg_en,
  input  logic              ps_dg_mdfy,
  input  logic              ps_dg_pre,
  input  logic              ps_dg_brev,
  input  logic [IDX_W-1:0]  ps_dg_iadd,
  input  logic [IDX_W-1:0]  ps_dg_madd,
  input  logic              ps_dg_wrt_en,
  input  logic [RA_W-1:0]   ps_dg_wrt_add,
  input  logic [RA_W-1:0]   ps_dg_rd_add,
  input  logic [DATA_W-1:0] bc_dg_dt,
  output logic [ADDR_W-1:0] dg_dm_add,
  output logic              dg_add_vld,
  output logic              dg_ps_wrap,
  output logic [DATA_W-1:0] dg_bc_dt
);

  typedef enum logic [1:0] {GRP_I = 2'd0, GRP_M = 2'd1, GRP_L = 2'd2, GRP_B = 2'd3} grp_e;

  logic [ADDR_W-1:0] i_reg [NREG];
  logic [ADDR_W-1:0] m_reg [NREG];
  logic [ADDR_W-1:0] l_reg [NREG];
  logic [ADDR_W-1:0] b_reg [NREG];

  logic [ADDR_W-1:0] i_cur, m_cur, l_cur, b_cur;
  logic [ADDR_W:0]   n_raw, n_adj, limit;
  logic [ADDR_W-1:0] n_new, addr_src, addr_rev;
  logic              wrap;
  logic              i_update;

  grp_e              wr_grp, rd_grp;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] wr_val, rd_val;

  assign i_cur = i_reg[ps_dg_iadd];
  assign m_cur = m_reg[ps_dg_madd];
  assign l_cur = l_reg[ps_dg_iadd];
  assign b_cur = b_reg[ps_dg_iadd];

  // I is unsigned, M is sign-extended; the extra bit keeps the end-of-buffer compare exact
  assign n_raw = {1'b0, i_cur} + {m_cur[ADDR_W-1], m_cur};
  assign limit = {1'b0, b_cur} + {1'b0, l_cur};

  always_comb begin
    wrap  = 1'b0;
    n_adj = n_raw;
    if (l_cur != '0) begin
      if (!m_cur[ADDR_W-1]) begin
        if (n_raw >= limit) begin
          n_adj = n_raw - {1'b0, l_cur};
          wrap  = 1'b1;
        end
      end else if (n_raw < {1'b0, b_cur}) begin
        n_adj = n_raw + {1'b0, l_cur};
        wrap  = 1'b1;
      end
    end
  end

  assign n_new    = n_adj[ADDR_W-1:0];
  assign addr_src = ps_dg_pre ? n_new : i_cur;
  assign i_update = ps_dg_en && (ps_dg_mdfy || !ps_dg_pre);

  always_comb begin
    addr_rev = '0;
    for (int unsigned k = 0; k < ADDR_W; k++) begin
      addr_rev[k] = addr_src[ADDR_W-1-k];
    end
  end

  assign wr_grp = grp_e'(ps_dg_wrt_add[RA_W-1 -: 2]);
  assign wr_idx = ps_dg_wrt_add[IDX_W-1:0];
  assign wr_val = bc_dg_dt[ADDR_W-1:0];
  assign rd_grp = grp_e'(ps_dg_rd_add[RA_W-1 -: 2]);
  assign rd_idx = ps_dg_rd_add[IDX_W-1:0];

  always_comb begin
    rd_val = '0;
    case (rd_grp)
      GRP_I: rd_val = i_reg[rd_idx];
      GRP_M: rd_val = m_reg[rd_idx];
      GRP_L: rd_val = l_reg[rd_idx];
      GRP_B: rd_val = b_reg[rd_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dg_dm_add  <= '0;
      dg_add_vld <= 1'b0;
      dg_ps_wrap <= 1'b0;
      dg_bc_dt   <= '0;
    end else begin
      if (i_update) begin
        i_reg[ps_dg_iadd] <= n_new;
      end
      // bus write is applied after the modify so it wins on a same-channel collision
      if (ps_dg_wrt_en) begin
        case (wr_grp)
          GRP_I: i_reg[wr_idx] <= wr_val;
          GRP_M: m_reg[wr_idx] <= wr_val;
          GRP_L: l_reg[wr_idx] <= wr_val;
          GRP_B: begin
            b_reg[wr_idx] <= wr_val;
            i_reg[wr_idx] <= wr_val;
          end
        endcase
      end
      if (ps_dg_en && !ps_dg_mdfy) begin
        dg_dm_add <= ps_dg_brev ? addr_rev : addr_src;
      end
      dg_add_vld <= ps_dg_en && !ps_dg_mdfy;
      dg_ps_wrap <= ps_dg_en && wrap;
      dg_bc_dt   <= DATA_W'(rd_val);
    end
  end

endmodule
